// File: rtl/cpu_pkg.sv
// Shared core definitions: the sequencer state encoding, the register-specifier width,
// the ID/EX control-bit width, and the bundle of pipeline control outputs.
package cpu_pkg;

    localparam int REG_W  = 5;
    // Width of the ID/EX control field that idex_flush zeroes in the datapath.
    localparam int CTRL_W = 9;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_hold;
    } pipe_ctrl_t;

    // Free-running pipe: every stage loads and nothing is cleared.
    localparam pipe_ctrl_t CTRL_FLOW   = '{pc_write: 1'b1, ifid_write: 1'b1,
                                           ifid_flush: 1'b0, idex_flush: 1'b0,
                                           exmem_hold: 1'b0};
    // Whole pipe frozen behind the data memory.
    localparam pipe_ctrl_t CTRL_FROZEN = '{pc_write: 1'b0, ifid_write: 1'b0,
                                           ifid_flush: 1'b0, idex_flush: 1'b0,
                                           exmem_hold: 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_tmo.sv
// Memory-wait timeout counter. Counts while enabled, returns to zero on clear, and
// flags expiry in the cycle its count reaches MAX_WAIT-1 while still enabled.
module hazard_stall_ctrl_tmo #(
    parameter int TMO_W    = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] tmo;

    // Wait-cycle counter; clear has priority over counting.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tmo <= '0;
        end else if (clr) begin
            tmo <= '0;
        end else if (en) begin
            tmo <= tmo + 1'b1;
        end
    end

    assign expire = en && (tmo == TMO_W'(MAX_WAIT - 1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubble, taken-branch redirect and
// data-memory wait freeze, with a sticky timeout error.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles counter port.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int TMO_W    = 8,
    parameter int MAX_WAIT = 200
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    import cpu_pkg::*;

    state_t     state, state_next;
    logic       redirect_pend, redirect_pend_next;
    logic       load_use, mem_stall;
    logic       tmo_clr, tmo_en, tmo_expire;
    pipe_ctrl_t ctrl;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use  = ex_mem_read && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    // The timeout only runs while an access is outstanding in MEM_WAIT.
    assign tmo_en  = (state == MEM_WAIT) && !mem_ready;
    assign tmo_clr = (state != MEM_WAIT) || mem_ready;

    hazard_stall_ctrl_tmo #(
        .TMO_W   (TMO_W),
        .MAX_WAIT(MAX_WAIT)
    ) u_tmo (
        .clock (clock),
        .rst   (rst),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .expire(tmo_expire)
    );

    // State register plus the branch redirect deferred across a memory wait.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
        end else begin
            state         <= state_next;
            redirect_pend <= redirect_pend_next;
        end
    end

    // Next-state logic: enter the wait on a stalled access, leave on ready or timeout.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next         = state;
        redirect_pend_next = redirect_pend;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next         = MEM_WAIT;
                    redirect_pend_next = ex_branch_taken;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next         = RUN;
                    redirect_pend_next = 1'b0;
                end else if (tmo_expire) begin
                    state_next = ERROR;
                end
            end
            ERROR:   state_next = ERROR;
            default: state_next = RUN;
        endcase
    end

    // Output logic: pipe controls from state and current hazards, forced free-flowing in reset.
    always_comb begin
        ctrl = CTRL_FLOW;
        if (rst) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        ctrl = CTRL_FROZEN;
                    end else if (ex_branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_write   = 1'b0;
                        ctrl.ifid_write = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        ctrl.ifid_flush = redirect_pend;
                        ctrl.idex_flush = redirect_pend;
                    end else begin
                        ctrl = CTRL_FROZEN;
                    end
                end
                default: ctrl = CTRL_FROZEN;
            endcase
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign ifid_write = ctrl.ifid_write;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_hold = ctrl.exmem_hold;
    assign err        = (state == ERROR);

`ifdef HAZARD_PERF_CNT_EN
    // Saturating count of cycles the PC was held outside the ERROR state.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state != ERROR) && !ctrl.pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: behavioural model compared every cycle plus directed
// literal expectations. Honours HAZARD_PERF_CNT_EN for the stall_cycles port.
module tb_hazard_stall_ctrl;

    localparam int MAX_WAIT = 200;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hazard_stall_ctrl dut (
        .clock          (clock),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_hold     (exmem_hold),
        .err            (err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 = pipe running, 1 = waiting on memory, 2 = dead after timeout.
    int          m_mode   = 0;
    int          m_waited = 0;
    bit          m_pend   = 1'b0;
    logic [31:0] m_stalls = '0;

    // Expected {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, err}.
    function automatic logic [5:0] expect_out();
        logic lu;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (!rst)        return 6'b110000;
        if (m_mode == 2) return 6'b000011;
        if (m_mode == 1) return mem_ready ? {2'b11, m_pend, m_pend, 2'b00} : 6'b000010;
        if (mem_req && !mem_ready) return 6'b000010;
        if (ex_branch_taken)       return 6'b111100;
        if (lu)                    return 6'b000100;
        return 6'b110000;
    endfunction

    always @(posedge clock or negedge rst) begin
        logic [5:0] e;
        if (!rst) begin
            m_mode = 0; m_waited = 0; m_pend = 1'b0; m_stalls = '0;
        end else begin
            e = expect_out();
            if (m_mode != 2 && !e[5] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            case (m_mode)
                0: if (mem_req && !mem_ready) begin
                       m_mode = 1; m_waited = 0; m_pend = ex_branch_taken;
                   end
                1: if (mem_ready) begin
                       m_mode = 0; m_pend = 1'b0;
                   end else begin
                       m_waited++;
                       if (m_waited == MAX_WAIT) m_mode = 2;
                   end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison, mid-cycle on the falling edge.
    always @(negedge clock) begin
        check("cycle_ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, err},
              expect_out());
`ifdef HAZARD_PERF_CNT_EN
        check("cycle_stalls", stall_cycles, m_stalls);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int rs, input int rt, input bit uses_rt, input bit mrd,
                          input int ert, input bit br, input bit req, input bit rdy);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses_rt; ex_mem_read = mrd;
        ex_rt = 5'(ert); ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a load-use pattern present: pipe must still flow.
        set_in(5, 0, 0, 1, 5, 0, 0, 0);
        #3;
        check("rst_pc_write", pc_write, 1'b1);
        check("rst_idex_flush", idex_flush, 1'b0);
        check("rst_err", err, 1'b0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("idle_pc_write", pc_write, 1'b1);

        // lw r5 ; add r6,r5,r1 -> one bubble.
        tick(); set_in(5, 1, 0, 1, 5, 0, 0, 0);
        @(negedge clock);
        check("lu_rs_pc_write", pc_write, 1'b0);
        check("lu_rs_ifid_write", ifid_write, 1'b0);
        check("lu_rs_idex_flush", idex_flush, 1'b1);
        tick(); set_in(5, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("lu_after_pc_write", pc_write, 1'b1);
        check("lu_after_idex_flush", idex_flush, 1'b0);

        // rt dependency only when rt is a source.
        tick(); set_in(2, 7, 1, 1, 7, 0, 0, 0);
        @(negedge clock);
        check("lu_rt_idex_flush", idex_flush, 1'b1);
        tick(); set_in(2, 7, 0, 1, 7, 0, 0, 0);
        @(negedge clock);
        check("rt_unused_pc_write", pc_write, 1'b1);

        // r0 never stalls.
        tick(); set_in(0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clock);
        check("r0_pc_write", pc_write, 1'b1);
        check("r0_idex_flush", idex_flush, 1'b0);

        // Branch beats load-use.
        tick(); set_in(5, 1, 0, 1, 5, 1, 0, 0);
        @(negedge clock);
        check("br_lu_ifid_flush", ifid_flush, 1'b1);
        check("br_lu_idex_flush", idex_flush, 1'b1);
        check("br_lu_pc_write", pc_write, 1'b1);

        // Fresh reset, then 3-cycle memory wait with branch in the first cycle.
        tick(); rst = 1'b0; #2 rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 1, 1, 0);
        @(negedge clock);
        check("mw1_hold", exmem_hold, 1'b1);
        check("mw1_pc_write", pc_write, 1'b0);
        check("mw1_ifid_flush", ifid_flush, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        check("mw2_hold", exmem_hold, 1'b1);
        tick();
        @(negedge clock);
        check("mw3_pc_write", pc_write, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        check("mw_rel_ifid_flush", ifid_flush, 1'b1);
        check("mw_rel_idex_flush", idex_flush, 1'b1);
        check("mw_rel_pc_write", pc_write, 1'b1);
        check("mw_rel_hold", exmem_hold, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("mw_after_ifid_flush", ifid_flush, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        check("mw_stall_cycles", stall_cycles, 32'd3);
`endif

        // mem_ready without a request does nothing.
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        check("stray_ready_pc_write", pc_write, 1'b1);
        check("stray_ready_hold", exmem_hold, 1'b0);

        // Reset in MEM_WAIT discards the deferred redirect.
        tick(); set_in(0, 0, 0, 0, 0, 1, 1, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        check("rstw_waiting_hold", exmem_hold, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("rstw_pc_write", pc_write, 1'b1);
        check("rstw_hold", exmem_hold, 1'b0);
        check("rstw_err", err, 1'b0);
        tick(); rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        check("rstw_no_ifid_flush", ifid_flush, 1'b0);
        check("rstw_no_idex_flush", idex_flush, 1'b0);

        // Timeout: ready never comes.
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (MAX_WAIT) tick();
        @(negedge clock);
        check("tmo_last_wait_err", err, 1'b0);
        check("tmo_last_wait_pc_write", pc_write, 1'b0);
        tick();
        @(negedge clock);
        check("tmo_err", err, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0, 1);
        @(negedge clock);
        check("err_frozen_pc_write", pc_write, 1'b0);
        check("err_frozen_hold", exmem_hold, 1'b1);
        check("err_sticky", err, 1'b1);
        tick(); rst = 1'b0;
        #1;
        check("err_rst_err", err, 1'b0);
        check("err_rst_pc_write", pc_write, 1'b1);
        tick(); rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("final_idle_pc_write", pc_write, 1'b1);

        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
